// File: rtl/onchip_mem_burst_reader.sv
// Avalon-MM burst read master for a fixed-latency on-chip RAM, feeding a FWFT FIFO
// that drives a valid/ready stream with an end-of-burst marker.
module onchip_mem_burst_reader #(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_read,
   input  logic [DATA_W-1:0] avm_readdata,
   output logic [DATA_W-1:0] st_data,
   output logic              st_valid,
   output logic              st_last,
   input  logic              st_ready
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

   state_t                  state_r;
   logic                    busy_r, done_r, read_r;
   logic [ADDR_W-1:0]       addr_r, next_addr_r;
   logic [ADDR_W:0]         req_left_r;
   logic [CW-1:0]           reserved_r, fifo_count_r;
   logic [READ_LATENCY-1:0] tag_valid_r, tag_last_r;
   logic [PW-1:0]           rd_ptr_r, wr_ptr_r;
   logic [DATA_W-1:0]       mem_data_r [FIFO_DEPTH];
   logic                    mem_last_r [FIFO_DEPTH];

   logic                    push_s, pop_s, last_issue_s, accept_s, issue_s;
   logic [CW-1:0]           reserved_base_s;
   logic [ADDR_W-1:0]       issue_addr_s;

   // reserved_r counts FIFO entries plus reads in flight plus the request on the bus,
   // so a new request is only issued when its data is guaranteed a FIFO slot.
   always_comb begin
      push_s          = tag_valid_r[READ_LATENCY-1];
      pop_s           = (fifo_count_r != '0) && st_ready;
      last_issue_s    = read_r && (req_left_r == '0);
      reserved_base_s = reserved_r - CW'(pop_s);
      accept_s        = (state_r == IDLE) && start && (word_count != '0);
      issue_s         = 1'b0;
      issue_addr_s    = next_addr_r;
      if (accept_s) begin
         issue_s      = 1'b1;
         issue_addr_s = base_addr;
      end else if ((state_r == READ) && (req_left_r != '0) && (reserved_base_s < DEPTH_C)) begin
         issue_s      = 1'b1;
         issue_addr_s = next_addr_r;
      end else begin
         issue_s      = 1'b0;
         issue_addr_s = next_addr_r;
      end
   end

   // Burst control FSM and registered request outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         read_r      <= 1'b0;
         addr_r      <= '0;
         next_addr_r <= '0;
         req_left_r  <= '0;
         reserved_r  <= '0;
      end else begin
         done_r     <= 1'b0;
         read_r     <= issue_s;
         reserved_r <= reserved_base_s + CW'(issue_s);
         if (issue_s) begin
            addr_r      <= issue_addr_s;
            next_addr_r <= issue_addr_s + ADDR_W'(1);
         end
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  busy_r     <= 1'b1;
                  state_r    <= READ;
                  req_left_r <= word_count - (ADDR_W + 1)'(1);
               end else if (start) begin
                  done_r <= 1'b1;
               end
            end
            READ: begin
               if (issue_s) begin
                  req_left_r <= req_left_r - (ADDR_W + 1)'(1);
               end
               if (last_issue_s) begin
                  state_r <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop_s && st_last) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Return-tag pipeline aligned to the slave latency, and FIFO pointers/occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_valid_r  <= '0;
         tag_last_r   <= '0;
         rd_ptr_r     <= '0;
         wr_ptr_r     <= '0;
         fifo_count_r <= '0;
      end else begin
         tag_valid_r[0] <= read_r;
         tag_last_r[0]  <= last_issue_s;
         for (int i = 1; i < READ_LATENCY; i++) begin
            tag_valid_r[i] <= tag_valid_r[i-1];
            tag_last_r[i]  <= tag_last_r[i-1];
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         fifo_count_r <= fifo_count_r + CW'(push_s) - CW'(pop_s);
      end
   end

   // FIFO storage; contents are only observed while the occupancy says they are valid
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_data_r[wr_ptr_r] <= avm_readdata;
         mem_last_r[wr_ptr_r] <= tag_last_r[READ_LATENCY-1];
      end
   end

   assign busy           = busy_r;
   assign done           = done_r;
   assign avm_read       = read_r;
   assign avm_chipselect = read_r;
   assign avm_address    = addr_r;
   assign st_valid       = (fifo_count_r != '0);
   assign st_data        = mem_data_r[rd_ptr_r];
   assign st_last        = (fifo_count_r != '0) && mem_last_r[rd_ptr_r];
endmodule
